// File: rtl/semafor_pkg.sv
// Shared definitions for the intersection light controllers:
// state encoding and the state-to-code mapping used by the lamp logic.
package semafor_pkg;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_VERDE    = 3'd1,
    ST_GALBEN   = 3'd2,
    ST_ROSU_TOT = 3'd3,
    ST_PIETONI  = 3'd4
  } stare_t;

  // Raw 3-bit code of a state, as seen on stare_semafor.
  function automatic logic [2:0] cod_stare(input stare_t s);
    return 3'(s);
  endfunction

endpackage

// File: rtl/temporizator_faza.sv
// Loadable phase down-counter. It only moves on en_tick and reports done
// on the tick that finds it at zero, so a phase loaded with T-1 lasts T ticks.
module temporizator_faza #(
  parameter int unsigned      CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Load wins over counting; the counter holds at zero until the FSM reloads it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt <= RST_VAL;
    else if (load)                cnt <= load_val;
    else if (en_tick && cnt != '0) cnt <= cnt - 1'b1;
  end

  assign done = en_tick && (cnt == '0);

endmodule

// File: rtl/semafor_n_directii.sv
// Round-robin light controller for NUM_DIR approaches with an optional
// all-red pedestrian phase at the end of a rotation. Lamps are decoded
// straight from the state and direction registers.
module semafor_n_directii
  import semafor_pkg::*;
#(
  parameter int NUM_DIR    = 4,
  parameter int T_VERDE    = 8,
  parameter int T_GALBEN   = 3,
  parameter int T_ROSU_TOT = 2,
  parameter int T_PIETONI  = 6,
  parameter int CNT_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_tick,
  input  logic                       cerere_P,
  output logic [NUM_DIR-1:0]         verde,
  output logic [NUM_DIR-1:0]         galben,
  output logic [NUM_DIR-1:0]         rosu,
  output logic                       verde_P,
  output logic                       rosu_P,
  output logic [$clog2(NUM_DIR)-1:0] dir_activ,
  output logic [2:0]                 stare_semafor,
  output logic                       ready
);

  localparam int DIR_W = $clog2(NUM_DIR);

  localparam logic [2:0] S_INIT     = cod_stare(ST_INIT);
  localparam logic [2:0] S_VERDE    = cod_stare(ST_VERDE);
  localparam logic [2:0] S_GALBEN   = cod_stare(ST_GALBEN);
  localparam logic [2:0] S_ROSU_TOT = cod_stare(ST_ROSU_TOT);
  localparam logic [2:0] S_PIETONI  = cod_stare(ST_PIETONI);

  // Counter reload values: each phase is loaded with its duration minus one.
  localparam logic [CNT_W-1:0] L_VERDE    = CNT_W'(T_VERDE - 1);
  localparam logic [CNT_W-1:0] L_GALBEN   = CNT_W'(T_GALBEN - 1);
  localparam logic [CNT_W-1:0] L_ROSU_TOT = CNT_W'(T_ROSU_TOT - 1);
  localparam logic [CNT_W-1:0] L_PIETONI  = CNT_W'(T_PIETONI - 1);

  localparam logic [DIR_W-1:0] DIR_LAST = DIR_W'(NUM_DIR - 1);

  logic [2:0]       stare, stare_nxt;
  logic [DIR_W-1:0] dir, dir_nxt;
  logic             cerere_lat;
  logic             ready_nxt;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             done;
  logic             intra_pietoni;

  temporizator_faza #(
    .CNT_W   (CNT_W),
    .RST_VAL (L_ROSU_TOT)
  ) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .en_tick  (en_tick),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

  // Next-state, next-direction and counter reload; every phase change reloads.
  always_comb begin
    stare_nxt = stare;
    dir_nxt   = dir;
    load      = 1'b0;
    load_val  = L_ROSU_TOT;
    ready_nxt = 1'b0;
    case (stare)
      S_INIT: if (done) begin
        stare_nxt = S_VERDE;
        dir_nxt   = '0;
        load      = 1'b1;
        load_val  = L_VERDE;
      end
      S_VERDE: if (done) begin
        stare_nxt = S_GALBEN;
        load      = 1'b1;
        load_val  = L_GALBEN;
      end
      S_GALBEN: if (done) begin
        stare_nxt = S_ROSU_TOT;
        load      = 1'b1;
        load_val  = L_ROSU_TOT;
      end
      S_ROSU_TOT: if (done) begin
        load = 1'b1;
        if (dir != DIR_LAST) begin
          stare_nxt = S_VERDE;
          dir_nxt   = dir + 1'b1;
          load_val  = L_VERDE;
        end else if (cerere_lat) begin
          stare_nxt = S_PIETONI;
          load_val  = L_PIETONI;
        end else begin
          stare_nxt = S_VERDE;
          dir_nxt   = '0;
          load_val  = L_VERDE;
          ready_nxt = 1'b1;
        end
      end
      S_PIETONI: if (done) begin
        stare_nxt = S_VERDE;
        dir_nxt   = '0;
        load      = 1'b1;
        load_val  = L_VERDE;
        ready_nxt = 1'b1;
      end
      // Corrupted codes fall back to a full INIT clearance immediately.
      default: begin
        stare_nxt = S_INIT;
        dir_nxt   = '0;
        load      = 1'b1;
        load_val  = L_ROSU_TOT;
      end
    endcase
  end

  assign intra_pietoni = (stare_nxt == S_PIETONI) && (stare != S_PIETONI);

  // State, direction and the rotation-start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stare <= S_INIT;
      dir   <= '0;
      ready <= 1'b0;
    end else begin
      stare <= stare_nxt;
      dir   <= dir_nxt;
      ready <= ready_nxt;
    end
  end

  // Pedestrian request latch; entering the pedestrian phase consumes it,
  // and requests arriving during that phase are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   cerere_lat <= 1'b0;
    else if (intra_pietoni)                    cerere_lat <= 1'b0;
    else if (cerere_P && stare != S_PIETONI)   cerere_lat <= 1'b1;
  end

  // Per-approach lamp decode: only the served approach can leave red.
  for (genvar i = 0; i < NUM_DIR; i++) begin : g_lamp
    logic sel;
    assign sel       = (dir == DIR_W'(i));
    assign verde[i]  = sel && (stare == S_VERDE);
    assign galben[i] = sel && (stare == S_GALBEN);
    assign rosu[i]   = ~(verde[i] | galben[i]);
  end

  assign verde_P       = (stare == S_PIETONI);
  assign rosu_P        = ~verde_P;
  assign dir_activ     = dir;
  assign stare_semafor = stare;

endmodule

// File: doc/semafor_n_directii.md
# semafor_n_directii

Parametrised intersection light controller, the next generation of the fixed four-approach (S/E/V/N + pedestrian) semaphore modules. A single FSM serves NUM_DIR approaches in round-robin: green, yellow, all-red clearance, then the next approach. An optional all-red pedestrian phase is inserted at the end of a rotation when a pedestrian request is latched. Timing is counted in ticks of the existing clock divider, so the block sits between `clk_divider` and the lamp drivers.

## Interface
Parameters:
- NUM_DIR, 4: number of vehicle approaches, ≥2.
- T_VERDE, 8: green duration in ticks, ≥1.
- T_GALBEN, 3: yellow duration in ticks, ≥1.
- T_ROSU_TOT, 2: all-red clearance (and INIT) duration in ticks, ≥1.
- T_PIETONI, 6: pedestrian phase duration in ticks, ≥1.
- CNT_W, 8: phase counter width. Every duration must be ≤ 2^CNT_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en_tick  in  1  one-cycle timing pulse from `clk_divider`.
- cerere_P  in  1  pedestrian request, level or pulse.
- verde  out  NUM_DIR  green lamp per approach.
- galben  out  NUM_DIR  yellow lamp per approach.
- rosu  out  NUM_DIR  red lamp per approach.
- verde_P / rosu_P  out  1 each  pedestrian lamps.
- dir_activ  out  $clog2(NUM_DIR)  index of the approach being served.
- stare_semafor  out  3  state code.
- ready  out  1  one-cycle pulse marking the start of a new rotation.

## Operation
- State codes: INIT=0, VERDE=1, GALBEN=2, ROSU_TOT=3, PIETONI=4. Codes 5–7 are illegal and recover to INIT on the next clk.
- Phase counter:
  - Loaded with duration−1 on entry to each state.
  - Decrements on every clk where en_tick=1 and the counter is nonzero.
  - The state advances on the clk where en_tick=1 and the counter equals 0. Each state therefore lasts exactly T ticks.
- Transitions:
  - INIT → VERDE with dir 0.
  - VERDE → GALBEN → ROSU_TOT.
  - ROSU_TOT with dir < NUM_DIR−1 → VERDE with dir+1.
  - ROSU_TOT with dir = NUM_DIR−1 → PIETONI if the request latch is set, else VERDE with dir 0 (dir wraps).
  - PIETONI → VERDE with dir 0.
- Lamps are Moore outputs decoded from the registered state and dir:
  - VERDE: verde[dir]=1, rosu[dir]=0.
  - GALBEN: galben[dir]=1, rosu[dir]=0.
  - Every other approach, and all approaches in INIT, ROSU_TOT and PIETONI: rosu=1.
  - verde_P=1 and rosu_P=0 only in PIETONI; otherwise rosu_P=1.
  - At most one approach is non-red at any time.
- Request latch:
  - Set on any clk with cerere_P=1, except while in PIETONI.
  - Cleared on the transition into PIETONI. If a set and the clear coincide, the clear wins.
- ready is a registered output. It is high for the first clk of VERDE dir 0 when entered from the last ROSU_TOT or from PIETONI. It is not asserted on the exit from INIT.

## Timing
- Reset values: stare_semafor=INIT, dir_activ=0, counter=T_ROSU_TOT−1, latch=0, ready=0, rosu=all 1, galben=0, verde=0, rosu_P=1, verde_P=0.
- Reset takes effect asynchronously. Asserting it mid-phase forces all-red in the same cycle and discards the latch and counter.
- Lamp latency: lamps change in the same cycle as the state register, i.e. directly after the ticking clk edge. There is no extra pipeline stage.
- Without en_tick pulses the state and counter freeze indefinitely.
- Rotation length without the pedestrian phase: NUM_DIR·(T_VERDE+T_GALBEN+T_ROSU_TOT) ticks. The pedestrian phase adds T_PIETONI.

## Structure
- Shared package `semafor_pkg`:
  - the state encoding as a 3-bit enum;
  - a state-to-code mapping shared with the existing per-direction modules.
- Sub-module `temporizator_faza`: the loadable down-counter with tick enable. Inputs are load, load value and en_tick; output is done (counter=0 and en_tick).
- The top module holds the FSM, the dir counter, the request latch and the lamp decode.

## Test plan
- Defaults, en_tick=1 every clk, reset released at cycle 0:
  - INIT for cycles 0–1;
  - verde[0] for cycles 2–9, galben[0] for cycles 10–12, all-red for cycles 13–14, verde[1] from cycle 15;
  - ready first high at cycle 54 with dir_activ=0.
- cerere_P pulsed once during dir 2 green:
  - after dir 3 ROSU_TOT, PIETONI lasts 6 ticks with verde_P=1 and rosu=4'b1111;
  - then verde[0] with ready=1;
  - the next rotation has no pedestrian phase.
- en_tick every 4th clk: every phase lasts 4× its tick count; counter and state are unchanged on non-tick cycles.
- rst asserted mid-GALBEN on dir 1 with the latch set: outputs go to their reset values immediately; after release the sequence restarts from INIT with no pedestrian phase.
- cerere_P held high continuously: PIETONI runs every rotation; a request asserted only during PIETONI does not produce a second PIETONI.
- NUM_DIR=3, T_VERDE=1: dir_activ goes 0→1→2→0, and the green phase lasts one tick.
